// File: rtl/boid_update_engine_if.sv
// Boid update engine bus: self-state load, neighbour stream and result handshake.
interface boid_update_engine_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 6
);
    logic             start;
    logic             start_empty;
    logic [W-1:0]     self_x;
    logic [W-1:0]     self_y;
    logic [W-1:0]     self_vx;
    logic [W-1:0]     self_vy;
    logic             nbr_valid;
    logic             nbr_ready;
    logic [W-1:0]     nbr_x;
    logic [W-1:0]     nbr_y;
    logic [W-1:0]     nbr_vx;
    logic [W-1:0]     nbr_vy;
    logic             nbr_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_x;
    logic [W-1:0]     out_y;
    logic [W-1:0]     out_vx;
    logic [W-1:0]     out_vy;
    logic             busy;
    logic [CNT_W-1:0] nbr_count;

    modport master (
        output start, start_empty, self_x, self_y, self_vx, self_vy,
        output nbr_valid, nbr_x, nbr_y, nbr_vx, nbr_vy, nbr_last, out_ready,
        input  nbr_ready, out_valid, out_x, out_y, out_vx, out_vy, busy, nbr_count
    );

    modport slave (
        input  start, start_empty, self_x, self_y, self_vx, self_vy,
        input  nbr_valid, nbr_x, nbr_y, nbr_vx, nbr_vy, nbr_last, out_ready,
        output nbr_ready, out_valid, out_x, out_y, out_vx, out_vy, busy, nbr_count
    );
endinterface

// File: rtl/boid_update_engine.sv
// Single-boid update: accumulates neighbour statistics over a stream, then applies
// cohesion/alignment/separation, edge handling and speed limiting in two calc cycles.
module boid_update_engine #(
    parameter int unsigned W       = 32,
    parameter int unsigned FRAC    = 16,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned X_MAX   = 640,
    parameter int unsigned Y_MAX   = 480,
    parameter int unsigned MARGIN  = 100,
    parameter int unsigned VIS_SQ  = 1600,
    parameter int unsigned PROT_SQ = 64,
    parameter int unsigned VMIN    = 4,
    parameter int unsigned VMAX    = 8,
    parameter int unsigned TURN    = 32'h3333,
    parameter int unsigned CSH     = 11,
    parameter int unsigned MSH     = 4,
    parameter int unsigned ASH     = 4,
    parameter bit          WRAP    = 1'b0
) (
    input logic                 clk,
    input logic                 reset,
    boid_update_engine_if.slave bus
);

    typedef logic signed [W-1:0] word_t;
    typedef enum logic [2:0] {StIdle, StScan, StCalc1, StCalc2, StOut} state_e;

    localparam word_t        PROT_LIM = word_t'(longint'(PROT_SQ) << FRAC);
    localparam word_t        VIS_LIM  = word_t'(longint'(VIS_SQ) << FRAC);
    localparam word_t        LO_LIM   = word_t'(longint'(MARGIN) << FRAC);
    localparam word_t        X_HI     = word_t'((longint'(X_MAX) - longint'(MARGIN)) << FRAC);
    localparam word_t        Y_HI     = word_t'((longint'(Y_MAX) - longint'(MARGIN)) << FRAC);
    localparam word_t        X_MAX_FX = word_t'(longint'(X_MAX) << FRAC);
    localparam word_t        Y_MAX_FX = word_t'(longint'(Y_MAX) << FRAC);
    localparam word_t        TURN_W   = word_t'(TURN);
    localparam logic [W-1:0] ONE_FX   = W'(longint'(1) << FRAC);
    localparam logic [W-1:0] VMAX_FX  = W'(longint'(VMAX) << FRAC);
    localparam logic [W-1:0] VMIN_FX  = W'(longint'(VMIN) << FRAC);
    localparam logic [CNT_W-1:0] CNT_CAP = '1;

    state_e state_q, state_d;

    word_t px_q, py_q, vx_q, vy_q;
    word_t close_x_q, close_y_q, sum_x_q, sum_y_q, sum_vx_q, sum_vy_q;
    word_t out_x_q, out_y_q, out_vx_q, out_vy_q;
    logic [CNT_W-1:0] cnt_q;

    // Fixed-point multiply of a running sum by the reciprocal of the count.
    function automatic word_t scale(word_t sum, logic [W-1:0] r);
        logic signed [2*W-1:0] p;
        p = $signed({{W{sum[W-1]}}, sum}) * $signed({{W{1'b0}}, r});
        return word_t'(p >>> FRAC);
    endfunction

    function automatic word_t vt_axis(word_t pos, word_t v, word_t avg_p, word_t avg_v,
                                      word_t close, logic has_n, word_t hi);
        word_t t;
        word_t c;
        word_t m;
        c = avg_p - pos;
        m = avg_v - v;
        t = v + (close >>> ASH);
        if (has_n) t = t + (c >>> CSH) + (m >>> MSH);
        if (!WRAP) begin
            if (pos < LO_LIM)  t = t + TURN_W;
            else if (pos > hi) t = t - TURN_W;
        end
        return t;
    endfunction

    function automatic word_t limit_v(word_t v, logic fast, logic slow);
        if (fast) return v - (v >>> 2);
        if (slow) return v + (v >>> 2);
        return v;
    endfunction

    function automatic word_t wrap_pos(word_t p, word_t maxv);
        if (WRAP) begin
            if (p[W-1])        return p + maxv;
            else if (p >= maxv) return p - maxv;
        end
        return p;
    endfunction

    // Neighbour classification; squares are formed at double width.
    word_t                 dx, dy, d_sq;
    logic signed [2*W-1:0] dx_w, dy_w, d2_full;
    logic                  in_range, is_prot, is_vis, accept;

    assign dx       = px_q - word_t'(bus.nbr_x);
    assign dy       = py_q - word_t'(bus.nbr_y);
    assign dx_w     = $signed({{W{dx[W-1]}}, dx});
    assign dy_w     = $signed({{W{dy[W-1]}}, dy});
    assign d2_full  = (dx_w * dx_w + dy_w * dy_w) >>> FRAC;
    assign in_range = (d2_full[2*W-1:W-1] == '0);
    assign d_sq     = $signed(d2_full[W-1:0]);
    assign is_prot  = in_range && (d_sq < PROT_LIM);
    assign is_vis   = in_range && (d_sq < VIS_LIM);
    assign accept   = (state_q == StScan) && bus.nbr_valid;

    // CALC1: averages and steered velocity.
    logic [W-1:0] recip;
    logic         has_n;
    word_t        vt_x, vt_y;

    assign has_n = (cnt_q != '0);
    assign recip = has_n ? (ONE_FX / W'(cnt_q)) : '0;
    assign vt_x  = vt_axis(px_q, vx_q, scale(sum_x_q, recip), scale(sum_vx_q, recip),
                           close_x_q, has_n, X_HI);
    assign vt_y  = vt_axis(py_q, vy_q, scale(sum_y_q, recip), scale(sum_vy_q, recip),
                           close_y_q, has_n, Y_HI);

    // CALC2: alpha-max-beta-min speed estimate, limiting and position update.
    logic [W-1:0] ax, ay, amax, amin, speed;
    logic         fast, slow;
    word_t        vx_lim, vy_lim, px_new, py_new;

    assign ax     = vx_q[W-1] ? W'(-vx_q) : W'(vx_q);
    assign ay     = vy_q[W-1] ? W'(-vy_q) : W'(vy_q);
    assign amax   = (ax > ay) ? ax : ay;
    assign amin   = (ax > ay) ? ay : ax;
    assign speed  = amax + (amin >> 1);
    assign fast   = speed > VMAX_FX;
    assign slow   = speed < VMIN_FX;
    assign vx_lim = limit_v(vx_q, fast, slow);
    assign vy_lim = limit_v(vy_q, fast, slow);
    assign px_new = wrap_pos(px_q + vx_lim, X_MAX_FX);
    assign py_new = wrap_pos(py_q + vy_lim, Y_MAX_FX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = bus.start_empty ? StCalc1 : StScan;
            StScan:  if (bus.nbr_valid && bus.nbr_last) state_d = StCalc1;
            StCalc1: state_d = StCalc2;
            StCalc2: state_d = StOut;
            StOut:   if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.nbr_ready = (state_q == StScan);
        bus.out_valid = (state_q == StOut);
        bus.busy      = (state_q != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_q      <= '0;
            py_q      <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            close_x_q <= '0;
            close_y_q <= '0;
            sum_x_q   <= '0;
            sum_y_q   <= '0;
            sum_vx_q  <= '0;
            sum_vy_q  <= '0;
            cnt_q     <= '0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_vx_q  <= '0;
            out_vy_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        px_q      <= word_t'(bus.self_x);
                        py_q      <= word_t'(bus.self_y);
                        vx_q      <= word_t'(bus.self_vx);
                        vy_q      <= word_t'(bus.self_vy);
                        close_x_q <= '0;
                        close_y_q <= '0;
                        sum_x_q   <= '0;
                        sum_y_q   <= '0;
                        sum_vx_q  <= '0;
                        sum_vy_q  <= '0;
                        cnt_q     <= '0;
                    end
                end
                StScan: begin
                    if (accept) begin
                        // Protected range wins and stays live even once the count saturates.
                        if (is_prot) begin
                            close_x_q <= close_x_q + dx;
                            close_y_q <= close_y_q + dy;
                        end else if (is_vis && (cnt_q != CNT_CAP)) begin
                            sum_x_q  <= sum_x_q + word_t'(bus.nbr_x);
                            sum_y_q  <= sum_y_q + word_t'(bus.nbr_y);
                            sum_vx_q <= sum_vx_q + word_t'(bus.nbr_vx);
                            sum_vy_q <= sum_vy_q + word_t'(bus.nbr_vy);
                            cnt_q    <= cnt_q + 1'b1;
                        end
                    end
                end
                StCalc1: begin
                    vx_q <= vt_x;
                    vy_q <= vt_y;
                end
                StCalc2: begin
                    out_x_q  <= px_new;
                    out_y_q  <= py_new;
                    out_vx_q <= vx_lim;
                    out_vy_q <= vy_lim;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_vx    = out_vx_q;
    assign bus.out_vy    = out_vy_q;
    assign bus.nbr_count = cnt_q;

endmodule

// File: tb/tb_boid_update_engine.sv
// Randomized bench for boid_update_engine: two instances (edge-turn and toroidal) share
// stimulus and are compared against a plain-arithmetic boid model.
module tb_boid_update_engine;

    localparam int     W     = 32;
    localparam int     CNT_W = 6;
    localparam longint ONE   = 64'sd65536;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start, start_empty, nbr_valid, nbr_last, out_ready;
    logic [31:0] self_x, self_y, self_vx, self_vy, nbr_x, nbr_y, nbr_vx, nbr_vy;

    boid_update_engine_if #(.W(W), .CNT_W(CNT_W)) bus0 ();
    boid_update_engine_if #(.W(W), .CNT_W(CNT_W)) bus1 ();

    assign bus0.start = start;       assign bus1.start = start;
    assign bus0.start_empty = start_empty; assign bus1.start_empty = start_empty;
    assign bus0.self_x = self_x;     assign bus1.self_x = self_x;
    assign bus0.self_y = self_y;     assign bus1.self_y = self_y;
    assign bus0.self_vx = self_vx;   assign bus1.self_vx = self_vx;
    assign bus0.self_vy = self_vy;   assign bus1.self_vy = self_vy;
    assign bus0.nbr_valid = nbr_valid; assign bus1.nbr_valid = nbr_valid;
    assign bus0.nbr_x = nbr_x;       assign bus1.nbr_x = nbr_x;
    assign bus0.nbr_y = nbr_y;       assign bus1.nbr_y = nbr_y;
    assign bus0.nbr_vx = nbr_vx;     assign bus1.nbr_vx = nbr_vx;
    assign bus0.nbr_vy = nbr_vy;     assign bus1.nbr_vy = nbr_vy;
    assign bus0.nbr_last = nbr_last; assign bus1.nbr_last = nbr_last;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

    boid_update_engine #(.WRAP(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    boid_update_engine #(.WRAP(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int n_checks = 0;
    int n_errors = 0;

    longint q_x[$], q_y[$], q_vx[$], q_vy[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic longint w32(input longint v);
        logic [31:0] t;
        t = v[31:0];
        return longint'($signed(t));
    endfunction

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Boid rules in 64-bit arithmetic, reduced to 32-bit two's complement where the word wraps.
    function automatic void model(input longint sx, input longint sy, input longint svx,
                                  input longint svy, input bit wrap,
                                  output longint r[4], output longint rcnt);
        longint cl[2], sp[2], sv[2], p[2], v[2], vt[2], mx[2], avp[2], avv[2];
        longint n, dx, dy, d, recip, a0, a1, spd, vn, pn;
        cl = '{0, 0}; sp = '{0, 0}; sv = '{0, 0};
        n = 0;
        foreach (q_x[i]) begin
            dx = w32(sx - q_x[i]);
            dy = w32(sy - q_y[i]);
            d  = (dx * dx + dy * dy) >>> 16;
            if (d >= 64'sd2147483648) continue;
            if (d < 64 * ONE) begin
                cl[0] += dx; cl[1] += dy;
            end else if (d < 1600 * ONE && n < 63) begin
                sp[0] += q_x[i]; sp[1] += q_y[i];
                sv[0] += q_vx[i]; sv[1] += q_vy[i];
                n++;
            end
        end
        recip = (n == 0) ? 0 : ONE / n;
        p  = '{sx, sy};
        v  = '{svx, svy};
        mx = '{640, 480};
        for (int a = 0; a < 2; a++) begin
            avp[a] = w32((w32(sp[a]) * recip) >>> 16);
            avv[a] = w32((w32(sv[a]) * recip) >>> 16);
            vt[a]  = v[a] + (w32(cl[a]) >>> 4);
            if (n != 0) vt[a] += (w32(avp[a] - p[a]) >>> 11) + (w32(avv[a] - v[a]) >>> 4);
            vt[a] = w32(vt[a]);
            if (!wrap) begin
                if (p[a] < 100 * ONE) vt[a] = w32(vt[a] + 32'h3333);
                else if (p[a] > (mx[a] - 100) * ONE) vt[a] = w32(vt[a] - 32'h3333);
            end
        end
        a0  = labs(vt[0]);
        a1  = labs(vt[1]);
        spd = (a0 > a1) ? a0 + (a1 >> 1) : a1 + (a0 >> 1);
        for (int a = 0; a < 2; a++) begin
            if (spd > 8 * ONE)      vn = w32(vt[a] - (vt[a] >>> 2));
            else if (spd < 4 * ONE) vn = w32(vt[a] + (vt[a] >>> 2));
            else                    vn = vt[a];
            pn = w32(p[a] + vn);
            if (wrap) begin
                if (pn < 0) pn += mx[a] * ONE;
                else if (pn >= mx[a] * ONE) pn -= mx[a] * ONE;
            end
            r[a]     = w32(pn);
            r[a + 2] = vn;
        end
        rcnt = n;
    endfunction

    function automatic longint rnd_fx(input int lo, input int hi);
        return longint'(lo) * ONE + longint'($urandom_range((hi - lo) * 65536));
    endfunction

    task automatic clear_q();
        q_x.delete(); q_y.delete(); q_vx.delete(); q_vy.delete();
    endtask

    task automatic push_nbr(input longint x, input longint y, input longint vx,
                            input longint vy);
        q_x.push_back(x); q_y.push_back(y); q_vx.push_back(vx); q_vy.push_back(vy);
    endtask

    task automatic present_beat(input int i, input bit last);
        while ($urandom_range(3) == 0) begin
            nbr_valid = 1'b0;
            @(negedge clk);
        end
        if (i == 0) check("nbr_ready_scan", 32'(bus0.nbr_ready), 32'd1);
        nbr_valid = 1'b1;
        nbr_x = q_x[i][31:0]; nbr_y = q_y[i][31:0];
        nbr_vx = q_vx[i][31:0]; nbr_vy = q_vy[i][31:0];
        nbr_last = last;
        @(negedge clk);
    endtask

    // One full transaction; stall cycles hold out_ready low with an ignored start pulse.
    task automatic run_txn(input longint sx, input longint sy, input longint svx,
                           input longint svy, input int stall);
        longint      r0[4], r1[4], c0, c1;
        int          lat;
        logic [31:0] hx, hvx;
        bit          empty;
        empty = (q_x.size() == 0);
        @(negedge clk);
        self_x = sx[31:0]; self_y = sy[31:0]; self_vx = svx[31:0]; self_vy = svy[31:0];
        start = 1'b1; start_empty = empty;
        @(negedge clk);
        start = 1'b0; start_empty = 1'b0;
        for (int i = 0; i < q_x.size(); i++) present_beat(i, i == q_x.size() - 1);
        nbr_valid = 1'b0; nbr_last = 1'b0;
        lat = 1;
        while (!bus0.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        model(sx, sy, svx, svy, 1'b0, r0, c0);
        model(sx, sy, svx, svy, 1'b1, r1, c1);
        check("out_x", bus0.out_x, r0[0][31:0]);
        check("out_y", bus0.out_y, r0[1][31:0]);
        check("out_vx", bus0.out_vx, r0[2][31:0]);
        check("out_vy", bus0.out_vy, r0[3][31:0]);
        check("nbr_count", 32'(bus0.nbr_count), c0[31:0]);
        check("wrap_out_x", bus1.out_x, r1[0][31:0]);
        check("wrap_out_y", bus1.out_y, r1[1][31:0]);
        check("wrap_out_vx", bus1.out_vx, r1[2][31:0]);
        hx = bus0.out_x; hvx = bus0.out_vx;
        for (int k = 0; k < stall; k++) begin
            if (k == 1) begin
                self_x = 32'h0012_0000; start = 1'b1; start_empty = 1'b1;
            end else begin
                start = 1'b0; start_empty = 1'b0;
            end
            @(negedge clk);
            check("stall_out_x", bus0.out_x, hx);
            check("stall_out_vx", bus0.out_vx, hvx);
            check("stall_valid", 32'(bus0.out_valid), 32'd1);
            check("stall_busy", 32'(bus0.busy), 32'd1);
        end
        start = 1'b0; start_empty = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_busy", 32'(bus0.busy), 32'd0);
        check("idle_valid", 32'(bus0.out_valid), 32'd0);
    endtask

    initial begin
        longint sx, sy;
        reset = 1'b1;
        start = 0; start_empty = 0; nbr_valid = 0; nbr_last = 0; out_ready = 0;
        self_x = 0; self_y = 0; self_vx = 0; self_vy = 0;
        nbr_x = 0; nbr_y = 0; nbr_vx = 0; nbr_vy = 0;
        repeat (2) @(negedge clk);
        check("rst_nbr_ready", 32'(bus0.nbr_ready), 32'd0);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        check("rst_nbr_count", 32'(bus0.nbr_count), 32'd0);
        check("rst_out_x", bus0.out_x, 32'd0);
        reset = 1'b0;

        // Straight-line flight in the middle of the screen.
        clear_q();
        run_txn(320 * ONE, 240 * ONE, 5 * ONE, 0, 0);
        check("mid_x", bus0.out_x, 32'd325 << 16);
        check("mid_y", bus0.out_y, 32'd240 << 16);
        check("mid_vx", bus0.out_vx, 32'd5 << 16);
        check("mid_vy", bus0.out_vy, 32'd0);

        // Left margin turn.
        run_txn(50 * ONE, 240 * ONE, 5 * ONE, 0, 0);
        check("margin_vx", bus0.out_vx, (32'd5 << 16) + 32'h3333);
        check("margin_x", bus0.out_x, (32'd55 << 16) + 32'h3333);

        // Toroidal wrap past the right edge.
        run_txn(638 * ONE, 240 * ONE, 5 * ONE, 0, 0);
        check("wrap_edge_x", bus1.out_x, 32'd3 << 16);

        // Count saturation, then a protected-range beat.
        clear_q();
        for (int i = 0; i < 70; i++)
            push_nbr(320 * ONE + (i[0] ? -1 : 1) * rnd_fx(9, 20), 240 * ONE + rnd_fx(-20, 20),
                     rnd_fx(-8, 8), rnd_fx(-8, 8));
        push_nbr(318 * ONE, 240 * ONE, 0, 0);
        run_txn(320 * ONE, 240 * ONE, 5 * ONE, 0, 0);
        check("sat_count", 32'(bus0.nbr_count), 32'd63);

        // Output stall with an ignored start.
        clear_q();
        for (int i = 0; i < 6; i++)
            push_nbr(300 * ONE + rnd_fx(-40, 40), 200 * ONE + rnd_fx(-40, 40),
                     rnd_fx(-8, 8), rnd_fx(-8, 8));
        run_txn(300 * ONE, 200 * ONE, 3 * ONE, -2 * ONE, 5);

        // Random flocks.
        for (int t = 0; t < 30; t++) begin
            clear_q();
            sx = rnd_fx(0, 639);
            sy = rnd_fx(0, 479);
            for (int i = 0; i < int'($urandom_range(12)); i++)
                push_nbr(sx + rnd_fx(-50, 50), sy + rnd_fx(-50, 50), rnd_fx(-10, 10),
                         rnd_fx(-10, 10));
            run_txn(sx, sy, rnd_fx(-10, 10), rnd_fx(-10, 10), int'($urandom_range(2)));
        end

        // Reset in the middle of a scan.
        clear_q();
        for (int i = 0; i < 12; i++) push_nbr(330 * ONE, 240 * ONE + i * ONE, 0, 0);
        @(negedge clk);
        self_x = 32'd320 << 16; self_y = 32'd240 << 16; self_vx = 0; self_vy = 0;
        start = 1'b1; start_empty = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) present_beat(i, 1'b0);
        nbr_valid = 1'b0;
        check("pre_rst_count", 32'(bus0.nbr_count), 32'd10);
        reset = 1'b1;
        #1;
        check("mid_rst_nbr_ready", 32'(bus0.nbr_ready), 32'd0);
        check("mid_rst_count", 32'(bus0.nbr_count), 32'd0);
        check("mid_rst_busy", 32'(bus0.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        clear_q();
        run_txn(320 * ONE, 240 * ONE, 5 * ONE, 0, 0);
        check("post_rst_x", bus0.out_x, 32'd325 << 16);
        check("post_rst_vx", bus0.out_vx, 32'd5 << 16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/boid_update_engine.md
BOID_UPDATE_ENGINE -- requirements
Module: boid_update_engine

Interface
REQ-001 The module SHALL take parameter W, default 32, meaning the signed fixed-point word width.
REQ-002 The module SHALL take parameter FRAC, default 16, meaning the number of fraction bits.
REQ-003 The module SHALL take parameter CNT_W, default 6, meaning the neighbour-counter width; the cap is 2^CNT_W-1.
REQ-004 The module SHALL take parameters X_MAX, default 640, and Y_MAX, default 480, meaning the screen size in integer pixels.
REQ-005 The module SHALL take parameter MARGIN, default 100, meaning the turn-zone width in pixels.
REQ-006 The module SHALL take parameter VIS_SQ, default 1600, meaning the visual radius squared in pixels.
REQ-007 The module SHALL take parameter PROT_SQ, default 64, meaning the protected radius squared in pixels.
REQ-008 The module SHALL take parameters VMIN, default 4, and VMAX, default 8, meaning the speed limits in pixels per frame.
REQ-009 The module SHALL take parameter TURN, default 32'h3333, meaning the turn increment (0.2).
REQ-010 The module SHALL take parameters CSH, default 11, MSH, default 4, and ASH, default 4, meaning the arithmetic right-shift factors for centering, matching and avoidance.
REQ-011 The module SHALL take parameter WRAP, default 0, meaning the edge mode: 0 = turn at margins, 1 = toroidal wrap.
REQ-012 The module SHALL have ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  load self state
- start_empty  in  1  with start: no neighbours, skip SCAN
- self_x, self_y, self_vx, self_vy  in  W each  self state
- nbr_valid  in  1  neighbour beat valid
- nbr_ready  out  1  neighbour beat accepted
- nbr_x, nbr_y, nbr_vx, nbr_vy  in  W each  neighbour state
- nbr_last  in  1  final neighbour beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_x, out_y, out_vx, out_vy  out  W each  updated boid state
- busy  out  1  state is not IDLE
- nbr_count  out  CNT_W  accumulated visual-neighbour count

Function
REQ-013 The FSM SHALL have states IDLE, SCAN, CALC1, CALC2 and OUT.
REQ-014 In IDLE, start SHALL latch the self_* inputs, clear all accumulators, and go to CALC1 if start_empty is 1, otherwise to SCAN; start outside IDLE SHALL be ignored.
REQ-015 nbr_ready SHALL be 1 only in SCAN; a beat is accepted on nbr_valid && nbr_ready, and acceptance of a beat with nbr_last=1 SHALL move the FSM to CALC1 on the next edge.
REQ-016 For each accepted beat: dx = self_x-nbr_x and dy = self_y-nbr_y; d_sq = (dx*dx+dy*dy)>>>FRAC, computed at 2W width; a result that does not fit in W bits SHALL be treated as out of range.
REQ-017 If d_sq < PROT_SQ<<FRAC, the beat SHALL add dx to close_x and dy to close_y only.
REQ-018 Otherwise, if d_sq < VIS_SQ<<FRAC and nbr_count < 2^CNT_W-1, the beat SHALL add to sum_x, sum_y, sum_vx and sum_vy and increment nbr_count.
REQ-019 Otherwise (including when the count is saturated) the beat SHALL be discarded; the protected-range path SHALL remain active when the count is saturated.
REQ-020 CALC1 SHALL register avg = sum*recip(n), where recip(n) = floor(2^FRAC/n) and n = nbr_count; when n=0 the centering and matching terms SHALL be 0.
REQ-021 CALC1 SHALL register v_t = v + ((avg_pos-pos)>>>CSH) + ((avg_v-v)>>>MSH) + (close>>>ASH), per axis.
REQ-022 When WRAP=0, CALC1 SHALL also add TURN to v_t if pos < MARGIN, and subtract TURN if pos > MAX-MARGIN, per axis.
REQ-023 CALC2 SHALL compute speed = max(|vx|,|vy|) + (min(|vx|,|vy|)>>1).
REQ-024 CALC2 SHALL apply the speed limit: if speed > VMAX, v -= v>>>2; if speed < VMIN, v += v>>>2; otherwise v is unchanged.
REQ-025 CALC2 SHALL compute pos += v.
REQ-026 When WRAP=1, CALC2 SHALL add MAX to pos if pos < 0, and subtract MAX if pos >= MAX, per axis.
REQ-027 Results SHALL be registered into out_* on entry to OUT, and out_valid SHALL be 1 in OUT.
REQ-028 out_* and out_valid SHALL hold stable while out_ready=0; out_valid && out_ready SHALL return the FSM to IDLE.
REQ-029 Latency SHALL be exactly 3 cycles from the last-beat acceptance edge (or the start_empty edge) to out_valid=1.
REQ-030 All additions SHALL wrap modulo 2^W; all shifts SHALL be arithmetic.

Reset
REQ-031 reset SHALL, asynchronously and in any state, force IDLE and clear all accumulators, nbr_count, out_*, out_valid, nbr_ready and busy to 0.

Verification
REQ-032 Bench: start_empty, self=(320,240,5,0) -> out_valid 3 cycles later; out=(325,240,5,0).
REQ-033 Bench: start_empty, self=(50,240,5,0) -> out_vx=(5<<16)+0x3333; out_x=(55<<16)+0x3333.
REQ-034 Bench: 70 beats inside the visual range and outside the protected range -> nbr_count=63; 1 further beat at dx=2 still updates close_x.
REQ-035 Bench: out_ready=0 for 5 cycles in OUT -> outputs stable; a start pulse is ignored; busy=1.
REQ-036 Bench: reset asserted during SCAN after 10 beats -> immediately nbr_ready=0, nbr_count=0, busy=0; the next empty start behaves as in REQ-032.
REQ-037 Bench: WRAP=1, start_empty, self=(638,240,5,0) -> out_x=3<<16.
